// File: rtl/frame_scheduler_if.sv
// frame_scheduler_if: raster/game-logic handshake bundle for frame_scheduler
//   master: raster timing + game logic side (drives i_*, observes o_*)
//   slave : frame_scheduler (observes i_*, drives o_*)
interface frame_scheduler_if #(
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int OVR_CNT_WIDTH   = 8
);
  logic                       i_vs;
  logic                       i_de;
  logic                       i_pause;
  logic                       i_update_done;
  logic                       i_overrun_clr;
  logic                       o_update_start;
  logic                       o_commit;
  logic                       o_busy;
  logic [FRAME_CNT_WIDTH-1:0] o_frame_count;
  logic                       o_overrun;
  logic [OVR_CNT_WIDTH-1:0]   o_overrun_count;
  modport master (
    output i_vs, i_de, i_pause, i_update_done, i_overrun_clr,
    input  o_update_start, o_commit, o_busy, o_frame_count, o_overrun, o_overrun_count
  );
  modport slave (
    input  i_vs, i_de, i_pause, i_update_done, i_overrun_clr,
    output o_update_start, o_commit, o_busy, o_frame_count, o_overrun, o_overrun_count
  );
endinterface

// File: rtl/frame_scheduler.sv
// frame_scheduler: one game-state update per frame slot, tear-free commit at frame boundaries
//   clk_rgb : pixel clock
//   rst     : synchronous active-high reset
//   bus     : i_vs/i_de raster timing, i_pause, i_update_done, i_overrun_clr in;
//             o_update_start/o_commit pulses, o_busy, o_frame_count, o_overrun, o_overrun_count out
module frame_scheduler #(
  parameter int UPDATE_DIV      = 1,
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int OVR_CNT_WIDTH   = 8
) (
  input  logic             clk_rgb,
  input  logic             rst,
  frame_scheduler_if.slave bus
);
  localparam int DIV_W = UPDATE_DIV > 1 ? $clog2(UPDATE_DIV) : 1;
  typedef enum logic [1:0] {IDLE, UPDATE, LATE, PENDING} state_t;
  state_t                     r_state, w_next;
  logic                       r_vs_q, r_de_q;
  logic [DIV_W-1:0]           r_div_cnt;
  logic                       r_update_start, r_commit, r_busy, r_overrun;
  logic [FRAME_CNT_WIDTH-1:0] r_frame_count;
  logic [OVR_CNT_WIDTH-1:0]   r_overrun_count;
  logic                       w_vs_rise, w_de_rise, w_eligible, w_start, w_commit, w_miss;
  assign w_vs_rise  = bus.i_vs & ~r_vs_q;
  assign w_de_rise  = bus.i_de & ~r_de_q;
  assign w_eligible = (r_div_cnt == '0) & ~bus.i_pause;
  // A late update is held in PENDING so its commit lands on the next frame boundary, never mid-frame.
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_commit = 1'b0;
    w_miss   = 1'b0;
    case (r_state)
      IDLE: if (w_vs_rise && w_eligible) begin
        w_next  = UPDATE;
        w_start = 1'b1;
      end
      UPDATE: if (bus.i_update_done) begin
        w_next   = IDLE;
        w_commit = 1'b1;
      end else if (w_de_rise || w_vs_rise) begin
        w_next = LATE;
        w_miss = 1'b1;
      end
      LATE: w_next = bus.i_update_done ? PENDING : LATE;
      PENDING: if (w_vs_rise) begin
        w_commit = 1'b1;
        w_start  = w_eligible;
        w_next   = w_eligible ? UPDATE : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // vs_q/de_q reset high so levels already asserted at reset release do not count as edges.
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      r_state         <= IDLE;
      r_vs_q          <= 1'b1;
      r_de_q          <= 1'b1;
      r_div_cnt       <= '0;
      r_update_start  <= 1'b0;
      r_commit        <= 1'b0;
      r_busy          <= 1'b0;
      r_frame_count   <= '0;
      r_overrun       <= 1'b0;
      r_overrun_count <= '0;
    end else begin
      r_state        <= w_next;
      r_vs_q         <= bus.i_vs;
      r_de_q         <= bus.i_de;
      r_update_start <= w_start;
      r_commit       <= w_commit;
      r_busy         <= w_next != IDLE;
      if (w_vs_rise) begin
        r_div_cnt     <= (r_div_cnt == DIV_W'(UPDATE_DIV - 1)) ? '0 : r_div_cnt + 1'b1;
        r_frame_count <= r_frame_count + 1'b1;
      end
      if (w_miss) begin
        r_overrun       <= 1'b1;
        r_overrun_count <= bus.i_overrun_clr ? OVR_CNT_WIDTH'(1) :
                           (&r_overrun_count ? r_overrun_count : r_overrun_count + 1'b1);
      end else if (bus.i_overrun_clr) begin
        r_overrun       <= 1'b0;
        r_overrun_count <= '0;
      end
    end
  end
  assign bus.o_update_start  = r_update_start;
  assign bus.o_commit        = r_commit;
  assign bus.o_busy          = r_busy;
  assign bus.o_frame_count   = r_frame_count;
  assign bus.o_overrun       = r_overrun;
  assign bus.o_overrun_count = r_overrun_count;
endmodule
